// File: rtl/wbsram_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the SRAM controller.
package wbsram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } arb_state_t;

  // The SRAM controller acks 8 cycles after accept, so this must stay at 9 or more.
  localparam int DEFAULT_TIMEOUT = 12;

endpackage

// File: rtl/wbarb_watchdog.sv
// Outstanding-request tracking and hung-cycle abort for one arbitrated slave port.
module wbarb_watchdog
  import wbsram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int LGOUT   = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_accept,
  input  logic i_ack,
  output logic o_ack,
  output logic o_full,
  output logic o_abort,
  output logic o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [LGOUT-1:0] outstanding;
  logic [TW-1:0]    timer;
  logic             abort;
  logic             err;
  logic             expire;

  // Acks for requests we never issued, or that arrive after an abort, are swallowed.
  assign o_ack   = i_ack && (outstanding != '0) && !abort;
  assign o_full  = &outstanding;
  assign o_abort = abort;
  assign o_err   = err;
  assign expire  = (outstanding != '0) && !o_ack && !abort && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      outstanding <= '0;
      timer       <= '0;
      abort       <= 1'b0;
      err         <= 1'b0;
    end else if (i_clear) begin
      // Owner dropped cyc: this wins over a same-cycle expiry, so no err is raised.
      outstanding <= '0;
      timer       <= '0;
      abort       <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= expire;
      if (expire) begin
        abort <= 1'b1;
      end
      if (i_accept && !o_ack) begin
        outstanding <= outstanding + 1'b1;
      end else if (!i_accept && o_ack) begin
        outstanding <= outstanding - 1'b1;
      end
      if (o_ack || (outstanding == '0)) begin
        timer <= '0;
      end else if (!abort) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbsram_arbiter.sv
// Round-robin two-master pipelined Wishbone arbiter granting whole bus cycles to the SRAM controller.
module wbsram_arbiter
  import wbsram_arbiter_pkg::*;
#(
  parameter int AW      = 15,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int LGOUT   = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic          o_a_stall,
  output logic          o_a_ack,
  output logic          o_a_err,
  output logic [DW-1:0] o_a_data,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic          o_b_stall,
  output logic          o_b_ack,
  output logic          o_b_err,
  output logic [DW-1:0] o_b_data,
  output logic          o_s_cyc,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_data,
  output logic [DW/8-1:0] o_s_sel,
  input  logic          i_s_stall,
  input  logic          i_s_ack,
  input  logic [DW-1:0] i_s_data
);

  arb_state_t state, next_state;
  logic       last_b;
  logic       own_a, own_b;
  logic       owner_cyc, owner_stb;
  logic       wd_ack, wd_full, wd_abort, wd_err;
  logic       accept;

  assign own_a     = (state == OWN_A);
  assign own_b     = (state == OWN_B);
  assign owner_cyc = (own_a && i_a_cyc) || (own_b && i_b_cyc);
  assign owner_stb = (own_a && i_a_stb) || (own_b && i_b_stb);

  // Saturation also masks stb so the slave never takes a request the master sees stalled.
  assign o_s_cyc  = owner_cyc && !wd_abort;
  assign o_s_stb  = owner_cyc && owner_stb && !wd_abort && !wd_full;
  assign o_s_we   = own_b ? i_b_we   : i_a_we;
  assign o_s_addr = own_b ? i_b_addr : i_a_addr;
  assign o_s_data = own_b ? i_b_data : i_a_data;
  assign o_s_sel  = own_b ? i_b_sel  : i_a_sel;
  assign accept   = o_s_stb && !i_s_stall;

  assign o_a_stall = !own_a || i_s_stall || wd_abort || wd_full;
  assign o_b_stall = !own_b || i_s_stall || wd_abort || wd_full;
  assign o_a_ack   = own_a && wd_ack;
  assign o_b_ack   = own_b && wd_ack;
  assign o_a_err   = own_a && wd_err;
  assign o_b_err   = own_b && wd_err;
  assign o_a_data  = i_s_data;
  assign o_b_data  = i_s_data;

  wbarb_watchdog #(
    .TIMEOUT(TIMEOUT),
    .LGOUT  (LGOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clear  (!owner_cyc),
    .i_accept (accept),
    .i_ack    (i_s_ack),
    .o_ack    (wd_ack),
    .o_full   (wd_full),
    .o_abort  (wd_abort),
    .o_err    (wd_err)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      last_b <= 1'b1;
    end else begin
      state <= next_state;
      if (own_a && !i_a_cyc) begin
        last_b <= 1'b0;
      end else if (own_b && !i_b_cyc) begin
        last_b <= 1'b1;
      end
    end
  end

  // Every hand-over passes through IDLE, leaving one dead cycle between owners.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_a_cyc && i_a_stb && i_b_cyc && i_b_stb) begin
          next_state = last_b ? OWN_A : OWN_B;
        end else if (i_a_cyc && i_a_stb) begin
          next_state = OWN_A;
        end else if (i_b_cyc && i_b_stb) begin
          next_state = OWN_B;
        end
      end
      OWN_A:   if (!i_a_cyc) next_state = IDLE;
      OWN_B:   if (!i_b_cyc) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wbsram_arbiter.sv
// Scoreboard bench for wbsram_arbiter with a behavioural SRAM controller that acks 8 cycles after accept.
module tb_wbsram_arbiter;

  logic        clk, rst_n;
  logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [14:0] a_addr, b_addr, s_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, s_wdata, s_rdata;
  logic [3:0]  a_sel, b_sel, s_sel;
  logic        a_stall, a_ack, a_err, b_stall, b_ack, b_err;
  logic        s_cyc, s_stb, s_we, s_stall, s_ack;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  bit no_ack = 0;
  logic [31:0] mem [logic [14:0]];
  logic [3:0]  last_w_sel;
  logic [31:0] last_w_data;
  int          pend_cnt[$];
  logic [31:0] pend_dat[$];

  typedef struct {
    bit          m;
    bit          err;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  wbsram_arbiter #(.AW(15), .DW(32), .TIMEOUT(12), .LGOUT(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_wdata), .i_a_sel(a_sel),
    .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_err(a_err), .o_a_data(a_rdata),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_wdata), .i_b_sel(b_sel),
    .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_err(b_err), .o_b_data(b_rdata),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr),
    .o_s_data(s_wdata), .o_s_sel(s_sel),
    .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_data(s_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc_cnt++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got no handshake within bound, expected one (cycle %0d)", name, cyc_cnt);
  endtask

  task automatic expect_resp(input bit m, input bit err, input bit chk, input logic [31:0] d, input int c);
    exp_t e;
    e.m = m; e.err = err; e.chk_data = chk; e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic at_cycle(input int k);
    do @(negedge clk); while (cyc_cnt < k);
  endtask

  function automatic logic get_stall(input bit m);
    return m ? b_stall : a_stall;
  endfunction

  function automatic logic get_resp(input bit m);
    return m ? (b_ack || b_err) : (a_ack || a_err);
  endfunction

  task automatic set_ctl(input bit m, input logic cyc, input logic stb);
    if (m) begin b_cyc = cyc; b_stb = stb; end
    else begin a_cyc = cyc; a_stb = stb; end
  endtask

  // One complete single-beat bus cycle; hold keeps cyc up for extra cycles after the response.
  task automatic applyStimulus(input bit m, input logic we, input logic [14:0] addr,
                               input logic [31:0] data, input logic [3:0] sel, input int hold);
    int n;
    @(posedge clk); #1;
    if (m) begin b_we = we; b_addr = addr; b_wdata = data; b_sel = sel; end
    else begin a_we = we; a_addr = addr; a_wdata = data; a_sel = sel; end
    set_ctl(m, 1'b1, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (get_stall(m) && n < 40);
    if (get_stall(m)) report_timeout(m ? "b_stall_wait" : "a_stall_wait");
    @(posedge clk); #1;
    set_ctl(m, 1'b1, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!get_resp(m) && n < 40);
    if (!get_resp(m)) report_timeout(m ? "b_resp_wait" : "a_resp_wait");
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    set_ctl(m, 1'b0, 1'b0);
  endtask

  // SRAM controller model: accepts when not stalled, acks 8 cycles later, forgets everything when cyc drops.
  initial begin : sram_model
    logic        acc, awe;
    logic [14:0] aad;
    logic [31:0] adat, rd;
    logic [3:0]  asel;
    s_stall = 1'b0; s_ack = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clk);
      acc = s_cyc && s_stb && !s_stall;
      awe = s_we; aad = s_addr; adat = s_wdata; asel = s_sel;
      @(posedge clk); #1;
      s_ack = 1'b0;
      if (!s_cyc || !rst_n) begin
        pend_cnt.delete();
        pend_dat.delete();
      end else begin
        for (int i = 0; i < pend_cnt.size(); i++) pend_cnt[i] = pend_cnt[i] - 1;
        if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
          s_ack = 1'b1;
          s_rdata = pend_dat[0];
          void'(pend_cnt.pop_front());
          void'(pend_dat.pop_front());
        end
      end
      if (acc && rst_n) begin
        rd = mem.exists(aad) ? mem[aad] : (32'hC0DE0000 | 32'(aad));
        if (awe) begin
          for (int j = 0; j < 4; j++) if (asel[j]) rd[8*j +: 8] = adat[8*j +: 8];
          mem[aad] = rd;
          last_w_sel = asel;
          last_w_data = adat;
          rd = '0;
        end
        if (!no_ack) begin
          pend_cnt.push_back(8);
          pend_dat.push_back(rd);
        end
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    logic        rm, rerr;
    logic [31:0] rdat;
    forever begin
      @(negedge clk);
      if (a_ack || a_err || b_ack || b_err) begin
        rm   = b_ack || b_err;
        rerr = rm ? b_err : a_err;
        rdat = rm ? b_rdata : a_rdata;
        checkOutput("resp_exclusive", (a_ack && a_err) || (b_ack && b_err) ||
                    ((a_ack || a_err) && (b_ack || b_err)), 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL resp_unexpected: got m=%0d err=%0b at cycle %0d, expected none", rm, rerr, cyc_cnt);
        end else begin
          e = sb.pop_front();
          checkOutput("resp_master", rm, e.m);
          checkOutput("resp_is_err", rerr, e.err);
          checkOutput("resp_cycle", cyc_cnt, e.cyc);
          if (e.chk_data) checkOutput("resp_data", rdat, e.data);
        end
      end
    end
  end

  initial begin : stimulus
    int base;
    int bad;
    {a_cyc, a_stb, a_we, b_cyc, b_stb, b_we} = '0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0; a_sel = '0; b_sel = '0;
    mem[15'h0010] = 32'h12345678;
    mem[15'h0020] = 32'hA0A0A0A0;
    mem[15'h0030] = 32'hB0B0B0B0;
    mem[15'h0040] = 32'h11223344;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_s_cyc", s_cyc, 0);
    checkOutput("rst_s_stb", s_stb, 0);
    checkOutput("rst_a_ack", a_ack, 0);
    checkOutput("rst_b_ack", b_ack, 0);
    checkOutput("rst_a_err", a_err, 0);
    checkOutput("rst_b_err", b_err, 0);
    checkOutput("rst_a_stall", a_stall, 1);
    checkOutput("rst_b_stall", b_stall, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Tie straight after reset: A first, B two cycles after A drops cyc.
    #1 base = cyc_cnt + 1;
    expect_resp(0, 0, 1, 32'hA0A0A0A0, base + 10);
    expect_resp(1, 0, 1, 32'hB0B0B0B0, base + 22);
    fork
      applyStimulus(0, 1'b0, 15'h0020, '0, 4'hF, 0);
      applyStimulus(1, 1'b0, 15'h0030, '0, 4'hF, 0);
      begin
        at_cycle(base + 12);
        checkOutput("t2_dead_s_cyc", s_cyc, 0);
        checkOutput("t2_dead_b_stall", b_stall, 1);
        at_cycle(base + 13);
        checkOutput("t2_b_s_stb", s_stb, 1);
        checkOutput("t2_b_s_addr", s_addr, 15'h0030);
      end
    join
    repeat (2) @(posedge clk);

    // Sustained contention alternates owners A,B,A,B with 12 cycles per grant.
    #1 base = cyc_cnt + 1;
    expect_resp(0, 0, 1, 32'hC0DE0050, base + 10);
    expect_resp(1, 0, 1, 32'hC0DE0060, base + 22);
    expect_resp(0, 0, 1, 32'hC0DE0058, base + 34);
    expect_resp(1, 0, 1, 32'hC0DE0068, base + 46);
    fork
      begin
        applyStimulus(0, 1'b0, 15'h0050, '0, 4'hF, 0);
        applyStimulus(0, 1'b0, 15'h0058, '0, 4'hF, 0);
      end
      begin
        applyStimulus(1, 1'b0, 15'h0060, '0, 4'hF, 0);
        applyStimulus(1, 1'b0, 15'h0068, '0, 4'hF, 0);
      end
    join
    repeat (2) @(posedge clk);

    // A alone: forwarded one cycle late, acked 8 cycles after accept, B stalled throughout.
    #1 base = cyc_cnt + 1;
    expect_resp(0, 0, 1, 32'h12345678, base + 10);
    bad = 0;
    fork
      applyStimulus(0, 1'b0, 15'h0010, '0, 4'hF, 0);
      begin
        for (int k = base; k <= base + 11; k++) begin
          at_cycle(k);
          if (!b_stall) bad++;
          if (k == base) begin
            checkOutput("t1_no_stb_grant_cycle", s_stb, 0);
            checkOutput("t1_a_stall_grant_cycle", a_stall, 1);
          end
          if (k == base + 1) begin
            checkOutput("t1_s_stb", s_stb, 1);
            checkOutput("t1_s_addr", s_addr, 15'h0010);
            checkOutput("t1_a_stall_owned", a_stall, 0);
          end
        end
        checkOutput("t1_b_stall_cycles_low", bad, 0);
      end
    join
    repeat (2) @(posedge clk);

    // Partial write passes sel and data untouched; readback shows only the low two bytes changed.
    #1 base = cyc_cnt + 1;
    expect_resp(0, 0, 0, '0, base + 10);
    fork
      applyStimulus(0, 1'b1, 15'h0040, 32'hAABBCCDD, 4'b0011, 0);
      begin
        at_cycle(base + 1);
        checkOutput("t4_s_we", s_we, 1);
        checkOutput("t4_s_sel", s_sel, 4'b0011);
        checkOutput("t4_s_data", s_wdata, 32'hAABBCCDD);
      end
    join
    checkOutput("t4_slave_sel", last_w_sel, 4'b0011);
    checkOutput("t4_slave_data", last_w_data, 32'hAABBCCDD);
    repeat (2) @(posedge clk);
    #1 base = cyc_cnt + 1;
    expect_resp(0, 0, 1, 32'h1122CCDD, base + 10);
    applyStimulus(0, 1'b0, 15'h0040, '0, 4'hF, 0);
    repeat (2) @(posedge clk);

    // Silent slave: err 12 cycles after accept, bus dropped while A still holds cyc.
    no_ack = 1'b1;
    #1 base = cyc_cnt + 1;
    expect_resp(0, 1, 0, '0, base + 14);
    fork
      applyStimulus(0, 1'b0, 15'h0070, '0, 4'hF, 2);
      begin
        at_cycle(base + 13);
        checkOutput("t5_s_cyc_before_abort", s_cyc, 1);
        at_cycle(base + 15);
        checkOutput("t5_s_cyc_aborted", s_cyc, 0);
        checkOutput("t5_a_stall_aborted", a_stall, 1);
      end
    join
    no_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 base = cyc_cnt + 1;
    expect_resp(1, 0, 1, 32'hB0B0B0B0, base + 10);
    applyStimulus(1, 1'b0, 15'h0030, '0, 4'hF, 0);
    repeat (2) @(posedge clk);

    // Reset pulse with one read outstanding: bus released at once, nothing returned.
    #1 base = cyc_cnt + 1;
    @(posedge clk); #1;
    a_we = 1'b0; a_addr = 15'h0010; a_sel = 4'hF;
    set_ctl(0, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_ctl(0, 1'b1, 1'b0);
    at_cycle(base + 4);
    checkOutput("t6_in_flight_s_cyc", s_cyc, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_s_cyc", s_cyc, 0);
    checkOutput("t6_async_s_stb", s_stb, 0);
    checkOutput("t6_async_a_stall", a_stall, 1);
    set_ctl(0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 base = cyc_cnt + 1;
    expect_resp(0, 0, 1, 32'h12345678, base + 10);
    applyStimulus(0, 1'b0, 15'h0010, '0, 4'hF, 0);

    repeat (5) @(posedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
